// File: rtl/csa_accumulator.sv
// Carry-save accumulator: operands are summed in S/C form at one per cycle, then the
// pair is resolved into a binary result CHUNK bits per cycle before being offered downstream.
module csa_accumulator #(
    parameter int N     = 16,
    parameter int G     = 4,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [N+G-1:0]   out_data,
    output logic [7:0]       out_count,
    input  logic             out_ready,
    output logic [1:0]       dbgState
);

    localparam int ACC_W   = N + G;
    localparam int NCHUNK  = ACC_W / CHUNK;
    localparam int IDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if ((ACC_W % CHUNK) != 0) begin : gBadChunk
            $error("csa_accumulator: N+G must be a multiple of CHUNK");
        end
    endgenerate

    // Handshakes: an operand transfers on a rising edge with in_valid && in_ready;
    // a result transfers on a rising edge with out_valid && out_ready. Each side's
    // valid is ignored while the block is not in the phase that serves it.
    typedef enum logic [1:0] {
        ACC  = 2'd0,
        RES  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT stateQ, stateD;

    logic [ACC_W-1:0] sumQ, carryQ, resQ;
    logic [IDX_W-1:0] chunkIdx;
    logic             cinQ;
    logic [7:0]       countQ;

    logic [ACC_W-1:0] opX;
    logic [CHUNK:0]   chunkSum;

    assign opX = ACC_W'(in_data);

    // One slice of the ripple resolve; the carry is held in cinQ between cycles.
    assign chunkSum = {1'b0, sumQ[chunkIdx*CHUNK +: CHUNK]}
                    + {1'b0, carryQ[chunkIdx*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, cinQ};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= ACC;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            ACC:     if (in_valid && in_last) stateD = RES;
            RES:     if (chunkIdx == LAST_IDX) stateD = DONE;
            DONE:    if (out_ready) stateD = ACC;
            default: stateD = ACC;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (stateQ)
            ACC:     in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign out_data  = resQ;
    assign out_count = countQ;
    assign dbgState  = stateQ;

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sumQ     <= '0;
            carryQ   <= '0;
            resQ     <= '0;
            chunkIdx <= '0;
            cinQ     <= 1'b0;
            countQ   <= '0;
        end else begin
            case (stateQ)
                ACC: begin
                    if (in_valid) begin
                        sumQ   <= sumQ ^ carryQ ^ opX;
                        carryQ <= ((sumQ & carryQ) | (sumQ & opX) | (carryQ & opX)) << 1;
                        if (countQ != 8'hFF) countQ <= countQ + 8'd1;
                        if (in_last) begin
                            chunkIdx <= '0;
                            resQ     <= '0;
                            cinQ     <= 1'b0;
                        end
                    end
                end
                RES: begin
                    resQ[chunkIdx*CHUNK +: CHUNK] <= chunkSum[CHUNK-1:0];
                    cinQ <= chunkSum[CHUNK];
                    if (chunkIdx != LAST_IDX) chunkIdx <= chunkIdx + IDX_W'(1);
                end
                DONE: begin
                    if (out_ready) begin
                        sumQ   <= '0;
                        carryQ <= '0;
                        countQ <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
